uart_msg_dispatcher: RTL and testbench

Command-driven UART message printer: each received command byte selects one of NUM_MSGS messages stored in an external byte ROM, and the block streams that message to the UART transmitter. It generalises the fixed hello/world printer with a parametrised message count, a start/length descriptor table, a one-deep pending-command slot, an abort character and status outputs. It sits between the UART rx/tx cores and a synchronous message ROM.

---
 rtl/uart_msg_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_uart_msg_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_dispatcher.sv
// Command-driven UART message printer: a received command byte picks a message from an
// external synchronous byte ROM and streams it to the UART transmitter.
module uart_msg_dispatcher #(
    parameter int NUM_MSGS = 4,
    parameter int ROM_AW = 6,
    parameter logic [7:0] CMD_BASE = 8'h61,
    parameter logic [7:0] ABORT_CHAR = 8'h1B,
    parameter logic [NUM_MSGS*ROM_AW-1:0] MSG_START = {6'd32, 6'd18, 6'd9, 6'd0},
    parameter logic [NUM_MSGS*(ROM_AW+1)-1:0] MSG_LEN = {7'd0, 7'd14, 7'd9, 7'd9},
    localparam int CUR_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic [CUR_W-1:0]  cur_msg,
    output logic              msg_done,
    output logic              msg_aborted,
    output logic              cmd_overrun
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StLoad  = 2'd2;
    localparam logic [1:0] StSend  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [ROM_AW:0]   count_q, count_d;
    logic [CUR_W-1:0]  cur_msg_q, cur_msg_d;
    logic              pend_valid_q, pend_valid_d;
    logic [CUR_W-1:0]  pend_idx_q, pend_idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              overrun_q, overrun_d;

    logic [8:0]        cmd_off;
    logic              cmd_valid;
    logic              abort_cmd;
    logic [CUR_W-1:0]  cmd_idx;
    logic [CUR_W-1:0]  start_sel;
    logic [ROM_AW-1:0] start_addr;
    logic [ROM_AW:0]   start_len;

    // Bit 8 of the 9-bit difference flags bytes below CMD_BASE.
    assign cmd_off   = {1'b0, rx_data} - {1'b0, CMD_BASE};
    assign cmd_valid = new_rx_data && !cmd_off[8] && (cmd_off < 9'(NUM_MSGS));
    assign abort_cmd = new_rx_data && (rx_data == ABORT_CHAR);
    assign cmd_idx   = cmd_off[CUR_W-1:0];

    // A waiting pending entry always wins over a command arriving in the same cycle.
    assign start_sel  = pend_valid_q ? pend_idx_q : cmd_idx;
    assign start_addr = MSG_START[start_sel*ROM_AW +: ROM_AW];
    assign start_len  = MSG_LEN[start_sel*(ROM_AW+1) +: (ROM_AW+1)];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        cur_msg_d    = cur_msg_q;
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        tx_data_d    = tx_data_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        overrun_d    = overrun_q;

        if (abort_cmd) begin
            pend_valid_d = 1'b0;
            if (state_q != StIdle) begin
                state_d   = StIdle;
                aborted_d = 1'b1;
            end
        end else begin
            if (state_q == StIdle) begin
                // The pending entry is consumed now; a fresh command takes its place.
                if (pend_valid_q) begin
                    pend_valid_d = cmd_valid;
                    if (cmd_valid) begin
                        pend_idx_d = cmd_idx;
                    end
                end
            end else if (cmd_valid) begin
                if (pend_valid_q) begin
                    overrun_d = 1'b1;
                end
                pend_valid_d = 1'b1;
                pend_idx_d   = cmd_idx;
            end

            case (state_q)
                StIdle: begin
                    if (pend_valid_q || cmd_valid) begin
                        cur_msg_d = start_sel;
                        if (start_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            addr_d  = start_addr;
                            count_d = start_len;
                            state_d = StFetch;
                        end
                    end
                end
                StFetch: begin
                    state_d = StLoad;
                end
                StLoad: begin
                    tx_data_d = rom_data;
                    state_d   = StSend;
                end
                StSend: begin
                    if (!tx_busy) begin
                        addr_d  = addr_q + ROM_AW'(1);
                        count_d = count_q - (ROM_AW+1)'(1);
                        if (count_q == (ROM_AW+1)'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            count_q      <= '0;
            cur_msg_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            tx_data_q    <= 8'h00;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            cur_msg_q    <= cur_msg_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            tx_data_q    <= tx_data_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            overrun_q    <= overrun_d;
        end
    end

    // Strobe is combinational so it can never overlap tx_busy; abort and reset suppress it.
    assign new_tx_data = (state_q == StSend) && !tx_busy && !abort_cmd && !rst;
    assign tx_data     = tx_data_q;
    assign rom_addr    = addr_q;
    assign busy        = (state_q != StIdle);
    assign cur_msg     = cur_msg_q;
    assign msg_done    = done_q;
    assign msg_aborted = aborted_q;
    assign cmd_overrun = overrun_q;

endmodule

// File: tb/tb_uart_msg_dispatcher.sv
// Directed bench for uart_msg_dispatcher: default instance plus a wrap-around instance,
// each fed by a behavioural synchronous ROM holding 8'h40 + address.
module tb_uart_msg_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       busy;
    logic [1:0] cur_msg;
    logic       msg_done;
    logic       msg_aborted;
    logic       cmd_overrun;

    logic [7:0] rx_data2;
    logic       new_rx_data2;
    logic [7:0] tx_data2;
    logic       new_tx_data2;
    logic       tx_busy2 = 1'b0;
    logic [5:0] rom_addr2;
    logic [7:0] rom_data2;
    logic       busy2;
    logic [0:0] cur_msg2;
    logic       msg_done2;
    logic       msg_aborted2;
    logic       cmd_overrun2;

    uart_msg_dispatcher dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .cur_msg     (cur_msg),
        .msg_done    (msg_done),
        .msg_aborted (msg_aborted),
        .cmd_overrun (cmd_overrun)
    );

    uart_msg_dispatcher #(
        .NUM_MSGS  (2),
        .MSG_START ({6'd0, 6'd62}),
        .MSG_LEN   ({7'd1, 7'd4})
    ) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data2),
        .new_rx_data (new_rx_data2),
        .tx_data     (tx_data2),
        .new_tx_data (new_tx_data2),
        .tx_busy     (tx_busy2),
        .rom_addr    (rom_addr2),
        .rom_data    (rom_data2),
        .busy        (busy2),
        .cur_msg     (cur_msg2),
        .msg_done    (msg_done2),
        .msg_aborted (msg_aborted2),
        .cmd_overrun (cmd_overrun2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= 8'h40 + {2'b00, rom_addr};
        rom_data2 <= 8'h40 + {2'b00, rom_addr2};
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] tx_q[$];
    int         cyc_q[$];
    logic [7:0] tx2_q[$];
    int         done_cnt = 0;
    int         abort_cnt = 0;
    int         done2_cnt = 0;
    int         busy_viol = 0;
    int         space_viol = 0;
    int         last_cyc = -100;
    bit         busy_seen = 1'b0;
    bit         busy_mode = 1'b0;
    bit         arm = 1'b0;
    int         busy_cnt = 0;

    // Observe at the falling edge, away from the state update.
    always @(negedge clk) begin
        cyc++;
        if (new_tx_data) begin
            tx_q.push_back(tx_data);
            cyc_q.push_back(cyc);
            if (tx_busy) busy_viol++;
            if (cyc - last_cyc < 3) space_viol++;
            last_cyc = cyc;
            if (busy_mode) arm = 1'b1;
        end
        if (msg_done) done_cnt++;
        if (msg_aborted) abort_cnt++;
        if (busy) busy_seen = 1'b1;
        if (new_tx_data2) tx2_q.push_back(tx_data2);
        if (msg_done2) done2_cnt++;
    end

    // tx_busy rises one cycle after an accepted byte and stays high for 20 cycles.
    always @(posedge clk) begin
        #1;
        if (busy_cnt > 0) busy_cnt--;
        if (arm) begin
            busy_cnt = 20;
            arm = 1'b0;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        rx_data2 = b;
        new_rx_data2 = 1'b1;
        @(negedge clk);
        new_rx_data2 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_tx(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (tx_q.size() < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(tx_q.size() >= target), 1);
    endtask

    initial begin
        int d0;
        int a0;
        int sz;
        int n;

        rst = 1'b1;
        rx_data = 8'h00;
        new_rx_data = 1'b0;
        rx_data2 = 8'h00;
        new_rx_data2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_new_tx", 32'(new_tx_data), 0);
        check("rst_done", 32'(msg_done), 0);
        check("rst_overrun", 32'(cmd_overrun), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_cur_msg", 32'(cur_msg), 0);
        rst = 1'b0;

        // "a": ROM[0..8], one byte every 3 cycles.
        tx_q.delete();
        cyc_q.delete();
        send(8'h61);
        wait_done("t1_done", 1, 100);
        repeat (2) @(posedge clk);
        check("t1_count", 32'(tx_q.size()), 9);
        for (int i = 0; i < 9; i++) check("t1_data", 32'(tx_q[i]), 8'h40 + i);
        check("t1_span", 32'(cyc_q[8] - cyc_q[0]), 24);
        check("t1_spacing", 32'(space_viol), 0);
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 0);

        // "b" with a slow transmitter.
        tx_q.delete();
        cyc_q.delete();
        busy_mode = 1'b1;
        send(8'h62);
        wait_done("t2_done", 2, 400);
        busy_mode = 1'b0;
        repeat (25) @(posedge clk);
        check("t2_count", 32'(tx_q.size()), 9);
        for (int i = 0; i < 9; i++) check("t2_data", 32'(tx_q[i]), 8'h49 + i);
        check("t2_no_strobe_busy", 32'(busy_viol), 0);
        check("t2_gap", 32'(cyc_q[1] - cyc_q[0]), 21);
        check("t2_done_once", 32'(done_cnt), 2);

        // "c" then "a", "b" while busy: b overwrites a.
        tx_q.delete();
        send(8'h63);
        repeat (3) @(negedge clk);
        check("t3_cur_msg_c", 32'(cur_msg), 2);
        check("t3_busy", 32'(busy), 1);
        send(8'h61);
        repeat (4) @(negedge clk);
        send(8'h62);
        wait_done("t3_done", 4, 300);
        repeat (40) @(posedge clk);
        check("t3_count", 32'(tx_q.size()), 23);
        for (int i = 0; i < 14; i++) check("t3_data_c", 32'(tx_q[i]), 8'h52 + i);
        for (int i = 0; i < 9; i++) check("t3_data_b", 32'(tx_q[14 + i]), 8'h49 + i);
        check("t3_done_total", 32'(done_cnt), 4);
        @(negedge clk);
        check("t3_overrun", 32'(cmd_overrun), 1);
        check("t3_cur_msg_b", 32'(cur_msg), 1);

        // Empty message and ignored bytes.
        @(posedge clk);
        tx_q.delete();
        busy_seen = 1'b0;
        d0 = done_cnt;
        send(8'h64);
        repeat (4) @(posedge clk);
        check("t4_done", 32'(done_cnt), 32'(d0 + 1));
        check("t4_no_tx", 32'(tx_q.size()), 0);
        check("t4_busy_never", 32'(busy_seen), 0);
        send(8'h7A);
        send(8'h30);
        repeat (6) @(posedge clk);
        check("t4_ignored_done", 32'(done_cnt), 32'(d0 + 1));
        check("t4_ignored_tx", 32'(tx_q.size()), 0);
        check("t4_ignored_busy", 32'(busy_seen), 0);

        // Abort after 5 bytes of "c" with "a" pending; then ESC while idle.
        tx_q.delete();
        a0 = abort_cnt;
        d0 = done_cnt;
        send(8'h63);
        wait_tx("t5_wait2", 2, 50);
        send(8'h61);
        wait_tx("t5_wait5", 5, 50);
        send(8'h1B);
        repeat (40) @(posedge clk);
        check("t5_count", 32'(tx_q.size()), 5);
        for (int i = 0; i < 5; i++) check("t5_data", 32'(tx_q[i]), 8'h52 + i);
        check("t5_aborted", 32'(abort_cnt), 32'(a0 + 1));
        check("t5_no_done", 32'(done_cnt), 32'(d0));
        @(negedge clk);
        check("t5_idle", 32'(busy), 0);
        send(8'h1B);
        repeat (4) @(posedge clk);
        check("t5_idle_abort", 32'(abort_cnt), 32'(a0 + 1));

        // Wrap-around instance: start 62, length 4.
        send2(8'h61);
        n = 0;
        while (done2_cnt < 1 && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("t6_done", 32'(done2_cnt), 1);
        check("t6_count", 32'(tx2_q.size()), 4);
        check("t6_b0", 32'(tx2_q[0]), 8'h7E);
        check("t6_b1", 32'(tx2_q[1]), 8'h7F);
        check("t6_b2", 32'(tx2_q[2]), 8'h40);
        check("t6_b3", 32'(tx2_q[3]), 8'h41);

        // Reset in the middle of "c".
        tx_q.delete();
        send(8'h63);
        wait_tx("t7_wait3", 3, 50);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        sz = tx_q.size();
        @(negedge clk);
        check("t7_busy", 32'(busy), 0);
        check("t7_tx_data", 32'(tx_data), 0);
        check("t7_new_tx", 32'(new_tx_data), 0);
        check("t7_done", 32'(msg_done), 0);
        check("t7_aborted", 32'(msg_aborted), 0);
        check("t7_overrun", 32'(cmd_overrun), 0);
        check("t7_cur_msg", 32'(cur_msg), 0);
        check("t7_rom_addr", 32'(rom_addr), 0);
        repeat (5) @(posedge clk);
        check("t7_no_strobe", 32'(tx_q.size()), 32'(sz));
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        check("t7_stays_quiet", 32'(tx_q.size()), 32'(sz));
        @(negedge clk);
        check("t7_idle_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
